// File: rtl/cnl_job_dispatcher_if.sv
// Signal bundle between the job dispatcher and the host, the quads and the data mover.
interface cnl_job_dispatcher_if #(
    parameter int C_NUM_QUADS  = 4,
    parameter int C_JOB_WIDTH  = 128,
    parameter int C_FIFO_DEPTH = 8
);
    localparam int ID_W  = (C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1;
    localparam int INF_W = $clog2(C_FIFO_DEPTH + C_NUM_QUADS) + 1;

    logic                               job_in_valid;
    logic                               job_in_ready;
    logic [C_JOB_WIDTH-1:0]             job_in_data;
    logic [C_NUM_QUADS-1:0]             job_start;
    logic [C_NUM_QUADS-1:0]             job_accept;
    logic [C_NUM_QUADS*C_JOB_WIDTH-1:0] job_parameters;
    logic [C_NUM_QUADS-1:0]             job_fetch_request;
    logic [C_NUM_QUADS-1:0]             job_fetch_ack;
    logic [C_NUM_QUADS-1:0]             job_fetch_complete;
    logic [C_NUM_QUADS-1:0]             job_complete;
    logic [C_NUM_QUADS-1:0]             job_complete_ack;
    logic                               fetch_grant_valid;
    logic [ID_W-1:0]                    fetch_grant_id;
    logic                               fetch_done;
    logic                               done_valid;
    logic [ID_W-1:0]                    done_quad;
    logic [INF_W-1:0]                   jobs_inflight;
    logic                               err_spurious;

    // Dispatcher view
    modport master (
        input  job_in_valid, job_in_data, job_accept, job_fetch_request, job_complete, fetch_done,
        output job_in_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
               job_complete_ack, fetch_grant_valid, fetch_grant_id, done_valid, done_quad,
               jobs_inflight, err_spurious
    );

    // Host, quads and data mover view
    modport slave (
        output job_in_valid, job_in_data, job_accept, job_fetch_request, job_complete, fetch_done,
        input  job_in_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
               job_complete_ack, fetch_grant_valid, fetch_grant_id, done_valid, done_quad,
               jobs_inflight, err_spurious
    );
endinterface

// File: rtl/cnl_job_dispatcher.sv
// Multi-quad job dispatcher: buffers host job words, hands each to the lowest idle quad,
// sequences the per-quad job handshake and round-robin shares the single fetch path.
module cnl_job_dispatcher #(
    parameter int C_NUM_QUADS  = 4,
    parameter int C_JOB_WIDTH  = 128,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic                 clk_if,
    input  logic                 rst,
    cnl_job_dispatcher_if.master bus
);
    localparam int ID_W  = (C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1;
    localparam int PTR_W = $clog2(C_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(C_FIFO_DEPTH + C_NUM_QUADS) + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_WAIT_FETCH = 3'd2;
    localparam logic [2:0] S_FETCH      = 3'd3;
    localparam logic [2:0] S_COMPUTE    = 3'd4;

    logic [C_JOB_WIDTH-1:0] fifo_mem [C_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    logic [2:0]             state [C_NUM_QUADS];
    logic [C_NUM_QUADS-1:0] idle_mask;
    logic [C_NUM_QUADS-1:0] start_mask;
    logic [C_NUM_QUADS-1:0] wait_mask;
    logic [C_NUM_QUADS-1:0] compute_mask;

    logic                   disp_found;
    logic [ID_W-1:0]        disp_id;

    logic [ID_W-1:0]        rr_ptr;
    logic [C_NUM_QUADS-1:0] arb_req;
    logic                   arb_found;
    logic [ID_W-1:0]        arb_id;
    int                     arb_idx;
    logic                   grant_issue;
    logic                   fetch_hit;

    logic [C_NUM_QUADS-1:0] complete_hit;
    logic [C_NUM_QUADS-1:0] pending;
    logic [C_NUM_QUADS-1:0] done_mask;
    logic [C_NUM_QUADS-1:0] done_lowest;
    logic                   done_found;
    logic [ID_W-1:0]        done_id;
    logic [INF_W-1:0]       complete_cnt;

    assign fifo_full        = (fifo_count == CNT_W'(C_FIFO_DEPTH));
    assign fifo_empty       = (fifo_count == '0);
    assign bus.job_in_ready = !fifo_full && !rst;
    assign push             = bus.job_in_valid && bus.job_in_ready;
    assign pop              = !fifo_empty && disp_found;

    assign bus.job_start = start_mask;
    assign arb_req       = wait_mask & bus.job_fetch_request;
    assign grant_issue   = !bus.fetch_grant_valid && arb_found;
    assign fetch_hit     = bus.fetch_done && bus.fetch_grant_valid;
    assign complete_hit  = compute_mask & bus.job_complete;
    assign done_mask     = pending | complete_hit;

    // Decode per-quad state into masks and pick the lowest idle quad for dispatch
    always_comb begin
        idle_mask    = '0;
        start_mask   = '0;
        wait_mask    = '0;
        compute_mask = '0;
        disp_found   = 1'b0;
        disp_id      = '0;
        for (int q = 0; q < C_NUM_QUADS; q++) begin
            idle_mask[q]    = (state[q] == S_IDLE);
            start_mask[q]   = (state[q] == S_START);
            wait_mask[q]    = (state[q] == S_WAIT_FETCH);
            compute_mask[q] = (state[q] == S_COMPUTE);
            if (!disp_found && idle_mask[q]) begin
                disp_found = 1'b1;
                disp_id    = ID_W'(q);
            end
        end
    end

    // Round-robin search over eligible fetch requesters starting at the pointer
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_idx   = 0;
        for (int i = 0; i < C_NUM_QUADS; i++) begin
            arb_idx = (int'(rr_ptr) + i) % C_NUM_QUADS;
            if (!arb_found && arb_req[arb_idx]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(arb_idx);
            end
        end
    end

    // Lowest pending completion to report and number of completions acked this cycle
    always_comb begin
        done_found   = 1'b0;
        done_id      = '0;
        done_lowest  = '0;
        complete_cnt = '0;
        for (int i = 0; i < C_NUM_QUADS; i++) begin
            complete_cnt = complete_cnt + INF_W'(complete_hit[i]);
            if (!done_found && done_mask[i]) begin
                done_found     = 1'b1;
                done_id        = ID_W'(i);
                done_lowest[i] = 1'b1;
            end
        end
    end

    // Job word storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk_if) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.job_in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_if) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Per-quad job FSMs, parameter latches and the one-cycle handshake pulses
    always_ff @(posedge clk_if) begin
        if (rst) begin
            for (int q = 0; q < C_NUM_QUADS; q++) begin
                state[q] <= S_IDLE;
            end
            bus.job_parameters     <= '0;
            bus.job_fetch_ack      <= '0;
            bus.job_fetch_complete <= '0;
            bus.job_complete_ack   <= '0;
        end else begin
            bus.job_fetch_ack      <= '0;
            bus.job_fetch_complete <= '0;
            bus.job_complete_ack   <= '0;
            for (int q = 0; q < C_NUM_QUADS; q++) begin
                case (state[q])
                    S_IDLE: begin
                        if (pop && disp_id == ID_W'(q)) begin
                            state[q] <= S_START;
                            bus.job_parameters[q*C_JOB_WIDTH +: C_JOB_WIDTH] <= fifo_mem[rd_ptr];
                        end
                    end
                    S_START: begin
                        if (bus.job_accept[q]) begin
                            state[q] <= S_WAIT_FETCH;
                        end
                    end
                    S_WAIT_FETCH: begin
                        if (grant_issue && arb_id == ID_W'(q)) begin
                            state[q]             <= S_FETCH;
                            bus.job_fetch_ack[q] <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (fetch_hit && bus.fetch_grant_id == ID_W'(q)) begin
                            state[q]                  <= S_COMPUTE;
                            bus.job_fetch_complete[q] <= 1'b1;
                        end
                    end
                    S_COMPUTE: begin
                        if (bus.job_complete[q]) begin
                            state[q]                <= S_IDLE;
                            bus.job_complete_ack[q] <= 1'b1;
                        end
                    end
                    default: state[q] <= S_IDLE;
                endcase
            end
        end
    end

    // Shared fetch path ownership, round-robin pointer and the sticky spurious-done flag
    always_ff @(posedge clk_if) begin
        if (rst) begin
            bus.fetch_grant_valid <= 1'b0;
            bus.fetch_grant_id    <= '0;
            rr_ptr                <= '0;
            bus.err_spurious      <= 1'b0;
        end else begin
            if (grant_issue) begin
                bus.fetch_grant_valid <= 1'b1;
                bus.fetch_grant_id    <= arb_id;
                rr_ptr <= (arb_id == ID_W'(C_NUM_QUADS - 1)) ? '0 : arb_id + ID_W'(1);
            end else if (fetch_hit) begin
                bus.fetch_grant_valid <= 1'b0;
            end
            if (bus.fetch_done && !bus.fetch_grant_valid) begin
                bus.err_spurious <= 1'b1;
            end
        end
    end

    // Serialise completions onto done_valid/done_quad, lowest index first
    always_ff @(posedge clk_if) begin
        if (rst) begin
            pending        <= '0;
            bus.done_valid <= 1'b0;
            bus.done_quad  <= '0;
        end else begin
            bus.done_valid <= done_found;
            if (done_found) begin
                bus.done_quad <= done_id;
            end
            pending <= done_mask & ~done_lowest;
        end
    end

    // Jobs accepted but not yet acknowledged as complete
    always_ff @(posedge clk_if) begin
        if (rst) begin
            bus.jobs_inflight <= '0;
        end else begin
            bus.jobs_inflight <= bus.jobs_inflight + INF_W'(push) - complete_cnt;
        end
    end
endmodule

// File: tb/tb_cnl_job_dispatcher.sv
// Directed self-checking bench for cnl_job_dispatcher with four quads.
module tb_cnl_job_dispatcher;
    localparam int NQ = 4;
    localparam int JW = 128;
    localparam int FD = 8;

    logic clk_if = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    cnl_job_dispatcher_if #(.C_NUM_QUADS(NQ), .C_JOB_WIDTH(JW), .C_FIFO_DEPTH(FD)) bus ();

    cnl_job_dispatcher #(.C_NUM_QUADS(NQ), .C_JOB_WIDTH(JW), .C_FIFO_DEPTH(FD)) dut (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus.master)
    );

    always #5 clk_if = ~clk_if;

    function automatic logic [JW-1:0] make_word(input int tag);
        logic [31:0] t;
        t = 32'(tag);
        return {t, ~t, t, 32'hC0DE_0000};
    endfunction

    task automatic step();
        @(posedge clk_if);
        #1;
    endtask

    task automatic clear_inputs();
        bus.job_in_valid      = 1'b0;
        bus.job_in_data       = '0;
        bus.job_accept        = '0;
        bus.job_fetch_request = '0;
        bus.job_complete      = '0;
        bus.fetch_done        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.job_in_valid = 1'b1;
            bus.job_in_data  = make_word(base + i);
            step();
        end
        bus.job_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (bus.job_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b want 0", bus.job_in_ready); end
        n_checks++; if (bus.job_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_start: got %b want 0000", bus.job_start); end
        n_checks++; if (bus.fetch_grant_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_grant: got %b want 0", bus.fetch_grant_valid); end
        n_checks++; if (bus.jobs_inflight !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_inflight: got %0d want 0", bus.jobs_inflight); end
        n_checks++; if (bus.done_valid !== 1'b0 || bus.err_spurious !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_flags: got done=%b err=%b want 0 0", bus.done_valid, bus.err_spurious); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.job_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready: got %b want 1", bus.job_in_ready); end
    endtask

    task automatic test_single_job();
        $display("[TB] test_single_job");
        push_words(1, 10);
        n_checks++; if (bus.job_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_start_t1: got %b want 0000", bus.job_start); end
        n_checks++; if (bus.jobs_inflight !== 5'd1) begin n_fail++; $display("[TB] FAIL single_inflight_push: got %0d want 1", bus.jobs_inflight); end
        step();
        n_checks++; if (bus.job_start !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_start_t2: got %b want 0001", bus.job_start); end
        n_checks++; if (bus.job_parameters[0*JW +: JW] !== make_word(10)) begin n_fail++; $display("[TB] FAIL single_params: got %h want %h", bus.job_parameters[0*JW +: JW], make_word(10)); end
        bus.job_accept = 4'b0001;
        step();
        bus.job_accept = 4'b0000;
        n_checks++; if (bus.job_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_start_drop: got %b want 0000", bus.job_start); end
        bus.job_fetch_request = 4'b0001;
        step();
        bus.job_fetch_request = 4'b0000;
        n_checks++; if (bus.job_fetch_ack !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_fetch_ack: got %b want 0001", bus.job_fetch_ack); end
        n_checks++; if (bus.fetch_grant_valid !== 1'b1 || bus.fetch_grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL single_grant: got v=%b id=%0d want v=1 id=0", bus.fetch_grant_valid, bus.fetch_grant_id); end
        step();
        n_checks++; if (bus.job_fetch_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_ack_pulse: got %b want 0000", bus.job_fetch_ack); end
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done = 1'b0;
        n_checks++; if (bus.job_fetch_complete !== 4'b0001 || bus.fetch_grant_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_fetch_complete: got fc=%b v=%b want fc=0001 v=0", bus.job_fetch_complete, bus.fetch_grant_valid); end
        bus.job_complete = 4'b0001;
        step();
        bus.job_complete = 4'b0000;
        n_checks++; if (bus.job_complete_ack !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_complete_ack: got %b want 0001", bus.job_complete_ack); end
        n_checks++; if (bus.done_valid !== 1'b1 || bus.done_quad !== 2'd0) begin n_fail++; $display("[TB] FAIL single_done: got v=%b q=%0d want v=1 q=0", bus.done_valid, bus.done_quad); end
        n_checks++; if (bus.jobs_inflight !== 5'd0) begin n_fail++; $display("[TB] FAIL single_inflight_end: got %0d want 0", bus.jobs_inflight); end
        step();
        n_checks++; if (bus.done_valid !== 1'b0 || bus.job_complete_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_done_pulse: got v=%b ack=%b want 0 0000", bus.done_valid, bus.job_complete_ack); end
    endtask

    task automatic test_fifo_full();
        $display("[TB] test_fifo_full");
        do_reset();
        push_words(12, 100);
        n_checks++; if (bus.job_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b want 0", bus.job_in_ready); end
        n_checks++; if (bus.job_start !== 4'b1111) begin n_fail++; $display("[TB] FAIL full_start: got %b want 1111", bus.job_start); end
        n_checks++; if (bus.jobs_inflight !== 5'd12) begin n_fail++; $display("[TB] FAIL full_inflight: got %0d want 12", bus.jobs_inflight); end
        n_checks++; if (bus.job_parameters[1*JW +: JW] !== make_word(101)) begin n_fail++; $display("[TB] FAIL full_params1: got %h want %h", bus.job_parameters[1*JW +: JW], make_word(101)); end
        n_checks++; if (bus.job_parameters[3*JW +: JW] !== make_word(103)) begin n_fail++; $display("[TB] FAIL full_params3: got %h want %h", bus.job_parameters[3*JW +: JW], make_word(103)); end
        bus.job_accept = 4'b0100;
        step();
        bus.job_accept        = 4'b0000;
        bus.job_fetch_request = 4'b0100;
        step();
        bus.job_fetch_request = 4'b0000;
        n_checks++; if (bus.job_fetch_ack !== 4'b0100 || bus.fetch_grant_id !== 2'd2) begin n_fail++; $display("[TB] FAIL full_fetch_ack: got ack=%b id=%0d want 0100 2", bus.job_fetch_ack, bus.fetch_grant_id); end
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done   = 1'b0;
        bus.job_complete = 4'b0100;
        step();
        bus.job_complete = 4'b0000;
        n_checks++; if (bus.job_complete_ack !== 4'b0100 || bus.jobs_inflight !== 5'd11) begin n_fail++; $display("[TB] FAIL full_complete: got ack=%b inflight=%0d want 0100 11", bus.job_complete_ack, bus.jobs_inflight); end
        step();
        n_checks++; if (bus.job_start !== 4'b1111) begin n_fail++; $display("[TB] FAIL full_refill_start: got %b want 1111", bus.job_start); end
        n_checks++; if (bus.job_parameters[2*JW +: JW] !== make_word(104)) begin n_fail++; $display("[TB] FAIL full_refill_params: got %h want %h", bus.job_parameters[2*JW +: JW], make_word(104)); end
        n_checks++; if (bus.job_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_refill_ready: got %b want 1", bus.job_in_ready); end
        n_checks++; if (bus.jobs_inflight !== 5'd11) begin n_fail++; $display("[TB] FAIL full_refill_inflight: got %0d want 11", bus.jobs_inflight); end
    endtask

    task automatic test_arbitration();
        int          order[4];
        int          idx;
        logic [NQ-1:0] exp_oh;
        $display("[TB] test_arbitration");
        do_reset();
        push_words(4, 200);
        step();
        n_checks++; if (bus.job_start !== 4'b1111) begin n_fail++; $display("[TB] FAIL arb_all_start: got %b want 1111", bus.job_start); end
        bus.job_accept = 4'b1111;
        step();
        bus.job_accept        = 4'b0000;
        bus.job_fetch_request = 4'b1111;
        step();
        order = '{0, 1, 2, 3};
        for (int k = 0; k < 4; k++) begin
            idx = order[k];
            exp_oh = '0;
            exp_oh[idx] = 1'b1;
            n_checks++; if (bus.job_fetch_ack !== exp_oh || bus.fetch_grant_id !== 2'(idx) || bus.fetch_grant_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL arb_r1_grant%0d: got ack=%b id=%0d v=%b want %b %0d 1", k, bus.job_fetch_ack, bus.fetch_grant_id, bus.fetch_grant_valid, exp_oh, idx); end
            bus.fetch_done = 1'b1;
            step();
            bus.fetch_done = 1'b0;
            n_checks++; if (bus.job_fetch_complete !== exp_oh || bus.fetch_grant_valid !== 1'b0 || bus.job_fetch_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL arb_r1_done%0d: got fc=%b v=%b ack=%b want %b 0 0000", k, bus.job_fetch_complete, bus.fetch_grant_valid, bus.job_fetch_ack, exp_oh); end
            step();
        end
        bus.job_complete = 4'b1111;
        step();
        bus.job_complete = 4'b0000;
        n_checks++; if (bus.job_complete_ack !== 4'b1111) begin n_fail++; $display("[TB] FAIL arb_all_complete_ack: got %b want 1111", bus.job_complete_ack); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.done_valid !== 1'b1 || bus.done_quad !== 2'(k)) begin n_fail++; $display("[TB] FAIL arb_done_seq%0d: got v=%b q=%0d want 1 %0d", k, bus.done_valid, bus.done_quad, k); end
            step();
        end
        n_checks++; if (bus.done_valid !== 1'b0 || bus.jobs_inflight !== 5'd0) begin n_fail++; $display("[TB] FAIL arb_drained: got v=%b inflight=%0d want 0 0", bus.done_valid, bus.jobs_inflight); end
        push_words(4, 300);
        step();
        bus.job_accept = 4'b0010;
        step();
        bus.job_accept = 4'b0000;
        step();
        n_checks++; if (bus.job_fetch_ack !== 4'b0010) begin n_fail++; $display("[TB] FAIL arb_lone_q1: got %b want 0010", bus.job_fetch_ack); end
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done   = 1'b0;
        bus.job_complete = 4'b0010;
        step();
        bus.job_complete = 4'b0000;
        push_words(1, 304);
        step();
        n_checks++; if (bus.job_start !== 4'b1111 || bus.job_parameters[1*JW +: JW] !== make_word(304)) begin n_fail++; $display("[TB] FAIL arb_q1_refill: got start=%b p1=%h want 1111 %h", bus.job_start, bus.job_parameters[1*JW +: JW], make_word(304)); end
        bus.job_accept = 4'b1111;
        step();
        bus.job_accept = 4'b0000;
        step();
        order = '{2, 3, 0, 1};
        for (int k = 0; k < 4; k++) begin
            idx = order[k];
            exp_oh = '0;
            exp_oh[idx] = 1'b1;
            n_checks++; if (bus.job_fetch_ack !== exp_oh || bus.fetch_grant_id !== 2'(idx) || bus.fetch_grant_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL arb_r2_grant%0d: got ack=%b id=%0d v=%b want %b %0d 1", k, bus.job_fetch_ack, bus.fetch_grant_id, bus.fetch_grant_valid, exp_oh, idx); end
            bus.fetch_done = 1'b1;
            step();
            bus.fetch_done = 1'b0;
            n_checks++; if (bus.job_fetch_complete !== exp_oh || bus.fetch_grant_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_r2_done%0d: got fc=%b v=%b want %b 0", k, bus.job_fetch_complete, bus.fetch_grant_valid, exp_oh); end
            step();
        end
        bus.job_fetch_request = 4'b0000;
        n_checks++; if (bus.jobs_inflight !== 5'd4) begin n_fail++; $display("[TB] FAIL arb_r2_inflight: got %0d want 4", bus.jobs_inflight); end
    endtask

    task automatic test_simultaneous_complete();
        $display("[TB] test_simultaneous_complete");
        bus.job_complete = 4'b1010;
        step();
        bus.job_complete = 4'b0000;
        n_checks++; if (bus.job_complete_ack !== 4'b1010) begin n_fail++; $display("[TB] FAIL sim_ack: got %b want 1010", bus.job_complete_ack); end
        n_checks++; if (bus.done_valid !== 1'b1 || bus.done_quad !== 2'd1) begin n_fail++; $display("[TB] FAIL sim_done_first: got v=%b q=%0d want 1 1", bus.done_valid, bus.done_quad); end
        n_checks++; if (bus.jobs_inflight !== 5'd2) begin n_fail++; $display("[TB] FAIL sim_inflight: got %0d want 2", bus.jobs_inflight); end
        step();
        n_checks++; if (bus.done_valid !== 1'b1 || bus.done_quad !== 2'd3 || bus.job_complete_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL sim_done_second: got v=%b q=%0d ack=%b want 1 3 0000", bus.done_valid, bus.done_quad, bus.job_complete_ack); end
        step();
        n_checks++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_done_end: got %b want 0", bus.done_valid); end
    endtask

    task automatic test_spurious();
        $display("[TB] test_spurious");
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done = 1'b0;
        n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_flag: got %b want 1", bus.err_spurious); end
        n_checks++; if (bus.job_fetch_complete !== 4'b0000 || bus.fetch_grant_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_no_effect: got fc=%b v=%b want 0000 0", bus.job_fetch_complete, bus.fetch_grant_valid); end
        bus.job_complete = 4'b0101;
        step();
        bus.job_complete = 4'b0000;
        n_checks++; if (bus.job_complete_ack !== 4'b0101 || bus.jobs_inflight !== 5'd0) begin n_fail++; $display("[TB] FAIL spur_fsm_kept: got ack=%b inflight=%0d want 0101 0", bus.job_complete_ack, bus.jobs_inflight); end
        n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_sticky: got %b want 1", bus.err_spurious); end
        rst = 1'b1;
        step();
        n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_clear: got %b want 0", bus.err_spurious); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        $display("[TB] test_reset_mid_fetch");
        do_reset();
        push_words(1, 400);
        step();
        bus.job_accept = 4'b0001;
        step();
        bus.job_accept        = 4'b0000;
        bus.job_fetch_request = 4'b0001;
        step();
        bus.job_fetch_request = 4'b0000;
        n_checks++; if (bus.fetch_grant_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_grant: got %b want 1", bus.fetch_grant_valid); end
        rst = 1'b1;
        step();
        n_checks++; if (bus.fetch_grant_valid !== 1'b0 || bus.job_fetch_ack !== 4'b0000 || bus.job_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_outputs: got v=%b ack=%b start=%b want 0 0000 0000", bus.fetch_grant_valid, bus.job_fetch_ack, bus.job_start); end
        n_checks++; if (bus.jobs_inflight !== 5'd0 || bus.job_parameters !== '0 || bus.job_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_state: got inflight=%0d ready=%b want 0 0", bus.jobs_inflight, bus.job_in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.job_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ready_after: got %b want 1", bus.job_in_ready); end
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done = 1'b0;
        n_checks++; if (bus.job_fetch_complete !== 4'b0000 || bus.done_valid !== 1'b0 || bus.err_spurious !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_abandoned: got fc=%b done=%b err=%b want 0000 0 1", bus.job_fetch_complete, bus.done_valid, bus.err_spurious); end
    endtask

    // Sequence the scenarios and report
    initial begin
        test_reset();
        test_single_job();
        test_fifo_full();
        test_arbitration();
        test_simultaneous_complete();
        test_spurious();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
